// File: rtl/muladd_cont.sv
// muladd_cont: multiply-add functional-unit controller.
// Latches three signed operands on start and computes src1*src2 + src3.
// The multiply is an iterative radix-2 shift-add on the operand magnitudes,
// with the sign applied once afterwards, followed by a single add step.
// Only one operation is in flight at a time. The result, tag and overflow
// flag are returned to writeback with a one-cycle valid pulse.
module muladd_cont #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [TAG_W-1:0]  dest_tag,
    input  logic [DATA_W-1:0] source1_muladd_cont,
    input  logic [DATA_W-1:0] source2_muladd_cont,
    input  logic [DATA_W-1:0] source3_muladd_cont,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  result_tag,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   addend_q, addend_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                busy_q, busy_d;
    logic                result_valid_q, result_valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [TAG_W-1:0]    result_tag_q, result_tag_d;
    logic                overflow_q, overflow_d;

    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] prod_mag;
    logic [2*DATA_W-1:0] prod_signed;
    logic [2*DATA_W:0]   full_sum;
    logic [DATA_W+1:0]   hi_bits;
    logic                full_ovf;

    // Datapath helpers: operand magnitudes, one shift-add step and the final signed add.
    always_comb begin
        abs1 = source1_muladd_cont[DATA_W-1] ? (-source1_muladd_cont) : source1_muladd_cont;
        abs2 = source2_muladd_cont[DATA_W-1] ? (-source2_muladd_cont) : source2_muladd_cont;

        mul_sum = {1'b0, acc_q} + {1'b0, (mcand_q & {DATA_W{mplier_q[0]}})};

        prod_mag    = {acc_q, mplier_q};
        prod_signed = sign_q ? (-prod_mag) : prod_mag;
        full_sum    = {prod_signed[2*DATA_W-1], prod_signed}
                    + {{(DATA_W+1){addend_q[DATA_W-1]}}, addend_q};
        hi_bits     = full_sum[2*DATA_W:DATA_W-1];
        full_ovf    = ~((&hi_bits) | (~|hi_bits));
    end

    // Next-state logic for the controller FSM, multiplier registers and writeback outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        acc_d          = acc_q;
        sign_d         = sign_q;
        addend_d       = addend_q;
        tag_d          = tag_q;
        result_valid_d = 1'b0;
        result_d       = result_q;
        result_tag_d   = result_tag_q;
        overflow_d     = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (start) begin
                    mcand_d  = abs1;
                    mplier_d = abs2;
                    sign_d   = source1_muladd_cont[DATA_W-1] ^ source2_muladd_cont[DATA_W-1];
                    addend_d = source3_muladd_cont;
                    tag_d    = dest_tag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = mul_sum[DATA_W:1];
                    mplier_d = {mul_sum[0], mplier_q[DATA_W-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = ADD;
                    end
                end
            end
            ADD: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d       = full_sum[DATA_W-1:0];
                    result_tag_d   = tag_q;
                    overflow_d     = full_ovf;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MUL) || (state_d == ADD);
    end

    // State and output registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            acc_q          <= '0;
            sign_q         <= 1'b0;
            addend_q       <= '0;
            tag_q          <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            result_tag_q   <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            acc_q          <= acc_d;
            sign_q         <= sign_d;
            addend_q       <= addend_d;
            tag_q          <= tag_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            result_tag_q   <= result_tag_d;
            overflow_q     <= overflow_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_tag   = result_tag_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_muladd_cont.sv
// tb_muladd_cont: self-checking bench for the multiply-add controller.
// Expected results come from a plain 64-bit integer model of src1*src2+src3.
module tb_muladd_cont;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 5;
    localparam int LAT    = 33;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              flush = 1'b0;
    logic [TAG_W-1:0]  dest_tag = '0;
    logic [DATA_W-1:0] src1 = '0;
    logic [DATA_W-1:0] src2 = '0;
    logic [DATA_W-1:0] src3 = '0;
    logic              busy;
    logic              result_valid;
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  result_tag;
    logic              overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] exp_result = '0;
    logic              exp_ovf    = 1'b0;
    logic [TAG_W-1:0]  exp_tag    = '0;

    logic [DATA_W-1:0] specials [5] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                                         32'h8000_0000, 32'hFFFF_FFFF};

    muladd_cont #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .flush               (flush),
        .dest_tag            (dest_tag),
        .source1_muladd_cont (src1),
        .source2_muladd_cont (src2),
        .source3_muladd_cont (src3),
        .busy                (busy),
        .result_valid        (result_valid),
        .result              (result),
        .result_tag          (result_tag),
        .overflow            (overflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case a bounded wait is somehow bypassed.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision signed arithmetic, then truncate and range-check.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] c,
                                     output logic [31:0] r, output logic ov);
        longint full;
        longint lim;
        full = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
        lim  = longint'(1) <<< 31;
        r    = full[31:0];
        ov   = (full >= lim) || (full < -lim);
    endfunction

    function automatic logic [31:0] pickOperand();
        int v;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin
                v = int'($urandom_range(0, 40)) - 20;
                return 32'(v);
            end
            2: return specials[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    // Pulse start for one edge with the given operands, then scramble the operand inputs.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [TAG_W-1:0] t);
        refModel(a, b, c, exp_result, exp_ovf);
        exp_tag  = t;
        src1     = a;
        src2     = b;
        src3     = c;
        dest_tag = t;
        flush    = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        src1     = $urandom;
        src2     = $urandom;
        src3     = $urandom;
        dest_tag = TAG_W'($urandom);
    endtask

    // Wait (bounded) for result_valid; optionally re-pulse start at two sample indices.
    task automatic waitResult(input int poke_a, input int poke_b, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int j = 0; j <= LAT + 8; j++) begin
            if (busy === 1'b1) bcnt++;
            if (result_valid === 1'b1) begin
                lat = j;
                break;
            end
            if (j == poke_a || j == poke_b) begin
                start    = 1'b1;
                src1     = 32'd9;
                src2     = 32'd9;
                src3     = 32'd9;
                dest_tag = TAG_W'(9);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic checkResult(input string name, input int poke_a, input int poke_b);
        int lat;
        int bcnt;
        waitResult(poke_a, poke_b, lat, bcnt);
        checkOutput($sformatf("%s.latency", name), 64'(lat), 64'(LAT));
        checkOutput($sformatf("%s.busy_cycles", name), 64'(bcnt), 64'(LAT));
        checkOutput($sformatf("%s.result", name), 64'(result), 64'(exp_result));
        checkOutput($sformatf("%s.tag", name), 64'(result_tag), 64'(exp_tag));
        checkOutput($sformatf("%s.overflow", name), 64'(overflow), 64'(exp_ovf));
    endtask

    // Valid must be a single-cycle pulse, the unit idle, and the result held.
    task automatic checkAfterPulse(input string name);
        tick();
        checkOutput($sformatf("%s.valid_pulse", name), 64'(result_valid), 64'(0));
        checkOutput($sformatf("%s.busy_after", name), 64'(busy), 64'(0));
        checkOutput($sformatf("%s.result_hold", name), 64'(result), 64'(exp_result));
    endtask

    task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [TAG_W-1:0] t);
        applyStimulus(a, b, c, t);
        checkResult(name, -1, -1);
        checkAfterPulse(name);
    endtask

    initial begin
        logic [31:0]      prev_result;
        logic             prev_ovf;
        logic [TAG_W-1:0] prev_tag;
        int               rv_cnt;

        $display("[TB] starting muladd_cont bench");

        // Reset state
        repeat (2) tick();
        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.valid", 64'(result_valid), 64'(0));
        checkOutput("reset.result", 64'(result), 64'(0));
        checkOutput("reset.tag", 64'(result_tag), 64'(0));
        checkOutput("reset.overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        tick();

        // Directed operand patterns
        runOp("op_3x4p5", 32'd3, 32'd4, 32'd5, TAG_W'(7));
        runOp("op_neg7x6p2", 32'hFFFF_FFF9, 32'd6, 32'd2, TAG_W'(3));
        runOp("op_maxx2", 32'h7FFF_FFFF, 32'd2, 32'd0, TAG_W'(17));
        runOp("op_minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, TAG_W'(30));
        runOp("op_minxm1pm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, TAG_W'(1));
        runOp("op_zero", 32'd0, 32'd0, 32'd0, TAG_W'(31));
        runOp("op_minxmin", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, TAG_W'(12));

        // Start while busy is ignored; then back-to-back start in the DONE cycle
        applyStimulus(32'd2, 32'd3, 32'd1, TAG_W'(5));
        checkResult("busy_start", 5, 20);
        applyStimulus(32'd1, 32'd1, 32'd1, TAG_W'(6));
        checkResult("b2b", -1, -1);
        checkAfterPulse("b2b");

        // Flush during MUL: no result, old outputs retained
        prev_result = exp_result;
        prev_ovf    = exp_ovf;
        prev_tag    = exp_tag;
        applyStimulus(32'd100, 32'd200, 32'd300, TAG_W'(20));
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush.busy", 64'(busy), 64'(0));
        rv_cnt = 0;
        for (int j = 0; j < LAT + 8; j++) begin
            if (result_valid === 1'b1) rv_cnt++;
            tick();
        end
        checkOutput("flush.no_valid", 64'(rv_cnt), 64'(0));
        checkOutput("flush.result", 64'(result), 64'(prev_result));
        checkOutput("flush.tag", 64'(result_tag), 64'(prev_tag));
        checkOutput("flush.overflow", 64'(overflow), 64'(prev_ovf));

        // Flush with start in idle accepts nothing
        src1     = 32'd4;
        src2     = 32'd4;
        src3     = 32'd4;
        start    = 1'b1;
        flush    = 1'b1;
        tick();
        start    = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_start.busy", 64'(busy), 64'(0));
        rv_cnt = 0;
        for (int j = 0; j < LAT + 8; j++) begin
            if (result_valid === 1'b1) rv_cnt++;
            tick();
        end
        checkOutput("flush_start.no_valid", 64'(rv_cnt), 64'(0));
        checkOutput("flush_start.result", 64'(result), 64'(prev_result));

        // Asynchronous reset mid-MUL, then a fresh op
        applyStimulus(32'd1234, 32'd5678, 32'd9, TAG_W'(11));
        repeat (15) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst.busy", 64'(busy), 64'(0));
        checkOutput("async_rst.valid", 64'(result_valid), 64'(0));
        checkOutput("async_rst.result", 64'(result), 64'(0));
        checkOutput("async_rst.tag", 64'(result_tag), 64'(0));
        checkOutput("async_rst.overflow", 64'(overflow), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst.busy", 64'(busy), 64'(0));
        runOp("post_rst", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd10, TAG_W'(9));

        // Randomized operations, some issued back-to-back from the DONE cycle
        for (int i = 0; i < 24; i++) begin
            applyStimulus(pickOperand(), pickOperand(), pickOperand(), TAG_W'($urandom));
            checkResult($sformatf("rand%0d", i), -1, -1);
            if ($urandom_range(0, 1) == 1) begin
                checkAfterPulse($sformatf("rand%0d", i));
            end
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muladd_cont.md
Name: muladd_cont

Overview:
- Downstream consumer of the source-operand routing stage: the multiply-add functional-unit controller.
- Latches three 32-bit operands on a start pulse and computes dest = src1*src2 + src3 (signed two's complement) with an iterative radix-2 shift-add multiplier.
- Returns the low 32 bits of the result, a destination tag and an overflow flag to writeback.
- Multi-cycle and non-pipelined: one operation in flight at a time.

Parameters:
DATA_W, 32, operand/result width (block verified at 32 only)
TAG_W, 5, destination register tag width
CNT_W, 5, iteration counter width (log2 DATA_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only when busy==0
flush  in  1  synchronous abort of in-flight op
dest_tag  in  TAG_W  destination tag, latched with operands
source1_muladd_cont  in  DATA_W  multiplicand
source2_muladd_cont  in  DATA_W  multiplier
source3_muladd_cont  in  DATA_W  addend
busy  out  1  high in MUL and ADD states
result_valid  out  1  one-cycle pulse, result present
result  out  DATA_W  low DATA_W bits of src1*src2+src3
result_tag  out  TAG_W  tag of the completed op
overflow  out  1  full result not representable in signed DATA_W

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. On assertion, state=IDLE and busy, result_valid, result, result_tag, overflow and the counter all go to 0.
- States:
  - IDLE: start=1 latches the operands and dest_tag, then goes to MUL with cnt=0.
  - MUL: 32 iterations, one per edge. cnt==31 goes to ADD.
  - ADD: one edge; goes to DONE.
  - DONE: one cycle with result_valid=1. start=1 behaves as in IDLE (back-to-back ops). Otherwise goes to IDLE.
- Latency: start sampled at edge k; result_valid is high between edges k+33 and k+34 (exactly one cycle).
- busy is 1 after edge k through the ADD state. busy is 0 in IDLE and DONE.
- Multiply method:
  - At latch, store |src1|, |src2| and sign = src1[31]^src2[31].
  - Each MUL edge: if the multiplier LSB is 1, add the multiplicand into the upper half of a 64-bit accumulator. Then shift {acc, multiplier} right by 1. Standard unsigned shift-add.
  - |0x80000000| is treated as the unsigned value 2^31 (no special case).
- ADD edge:
  - product = sign ? -acc : acc (64-bit signed).
  - full = sext65(product) + sext65(src3).
  - result <= full[31:0]; result_tag <= latched tag.
  - overflow <= (full[64:31] not all equal).
- result, result_tag and overflow hold their values until the next ADD edge or reset.
- start while busy==1: ignored. No latch, no error, and the in-flight op is unaffected.
- flush=1 in MUL or ADD: next state IDLE, no result_valid, and result/result_tag/overflow keep their old values.
- flush in IDLE/DONE: forces IDLE. It overrides a same-cycle start, so start+flush accepts nothing.
- Operand inputs are don't-care except on the accepting edge; later changes do not affect the in-flight op.
- rst_n deasserted mid-op: the op is lost. The first edge after release is in IDLE.
- Zero-operand cases take the full latency (no early termination).

Test Plan:
- Reset then start with src1=3, src2=4, src3=5, tag=7 -> after 33 edges result_valid=1 for 1 cycle, result=0x00000011, result_tag=7, overflow=0; busy high for 33 cycles.
- src1=0xFFFFFFF9 (-7), src2=6, src3=2 -> result=0xFFFFFFD8 (-40), overflow=0.
- src1=0x7FFFFFFF, src2=2, src3=0 -> result=0xFFFFFFFE, overflow=1.
- src1=0x80000000, src2=0xFFFFFFFF, src3=0 -> result=0x80000000, overflow=1. Same operands with src3=0xFFFFFFFF -> result=0x7FFFFFFF, overflow=0.
- Start (2,3,1), then re-pulse start with (9,9,9) at cycles 5 and 20 -> single result 0x00000007. Start asserted in the DONE cycle with (1,1,1) -> second result 0x00000002 exactly 33 edges later.
- flush at MUL cycle 10 -> no result_valid, result unchanged, busy=0 next cycle. Separately, drop rst_n mid-MUL -> all outputs 0 immediately (async); after release, a new op completes normally.
